// File: rtl/wtch_time_tx.sv
// -----------------------------------------------------------------------------
// wtch_time_tx : snapshots msec/sec/min/hour and streams "HH:MM:SS.CC\r\n" (Rev 1.0)
// Optional WTCH_AUTO_REPORT_EN: any change of sec while idle starts a report.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module wtch_time_tx #(
  parameter int ADD_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);

  localparam int         FRAME_LEN = (ADD_CRLF != 0) ? 13 : 12;
  localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic [6:0] snap_cs;
  logic [5:0] snap_s, snap_m;
  logic [4:0] snap_h;
  logic [7:0] bcd_h, bcd_m, bcd_s, bcd_c;
  logic [7:0] cur_byte;
  logic       auto_req;
  logic       start;

  // Two BCD digits {tens, units}; anything above 99 is clamped to 99.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] sat;
    sat = (v > 7'd99) ? 7'd99 : v;
    return {4'(sat / 7'd10), 4'(sat % 7'd10)};
  endfunction

  function automatic logic [7:0] ascii(input logic [3:0] d);
    return {4'h3, d};
  endfunction

`ifdef WTCH_AUTO_REPORT_EN
  logic [5:0] sec_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sec_q <= '0;
    else      sec_q <= sec;
  end

  assign auto_req = (sec != sec_q);
`else
  assign auto_req = 1'b0;
`endif

  assign start = req | auto_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      snap_cs <= '0;
      snap_s  <= '0;
      snap_m  <= '0;
      snap_h  <= '0;
      bcd_h   <= '0;
      bcd_m   <= '0;
      bcd_s   <= '0;
      bcd_c   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (state == IDLE && start) begin
        snap_cs <= msec;
        snap_s  <= sec;
        snap_m  <= min;
        snap_h  <= hour;
      end
      if (state == LOAD) begin
        bcd_h <= to_bcd({2'b00, snap_h});
        bcd_m <= to_bcd({1'b0, snap_m});
        bcd_s <= to_bcd({1'b0, snap_s});
        bcd_c <= to_bcd(snap_cs);
      end
    end
  end

  always_comb begin
    cur_byte = 8'h00;
    case (idx)
      4'd0:    cur_byte = ascii(bcd_h[7:4]);
      4'd1:    cur_byte = ascii(bcd_h[3:0]);
      4'd2:    cur_byte = 8'h3A;
      4'd3:    cur_byte = ascii(bcd_m[7:4]);
      4'd4:    cur_byte = ascii(bcd_m[3:0]);
      4'd5:    cur_byte = 8'h3A;
      4'd6:    cur_byte = ascii(bcd_s[7:4]);
      4'd7:    cur_byte = ascii(bcd_s[3:0]);
      4'd8:    cur_byte = 8'h2E;
      4'd9:    cur_byte = ascii(bcd_c[7:4]);
      4'd10:   cur_byte = ascii(bcd_c[3:0]);
      4'd11:   cur_byte = (ADD_CRLF != 0) ? 8'h0D : 8'h0A;
      4'd12:   cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        idx_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = DONE;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_wtch_time_tx.sv
// -----------------------------------------------------------------------------
// tb_wtch_time_tx : scoreboard bench for wtch_time_tx (CRLF and LF-only instances) (Rev 1.0)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_wtch_time_tx;

  logic       clk = 1'b0;
  logic       rst, req, tx_ready;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done;

  logic       lf_req;
  logic       lf_tx_ready = 1'b1;
  logic [6:0] lf_msec;
  logic [5:0] lf_sec, lf_min;
  logic [4:0] lf_hour;
  logic [7:0] lf_tx_data;
  logic       lf_tx_valid, lf_busy, lf_done;

  wtch_time_tx #(.ADD_CRLF(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .msec(msec), .sec(sec), .min(min), .hour(hour),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  wtch_time_tx #(.ADD_CRLF(0)) u_dut_lf (
    .clk(clk), .rst(rst), .req(lf_req), .msec(lf_msec), .sec(lf_sec), .min(lf_min),
    .hour(lf_hour), .tx_ready(lf_tx_ready), .tx_data(lf_tx_data), .tx_valid(lf_tx_valid),
    .busy(lf_busy), .done(lf_done)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_fail = 0, cyc = 0;
  int         n_done = 0, lf_n_done = 0, byte_in_frame = 0, lf_byte_in_frame = 0;
  logic [7:0] exp_q[$], lf_exp_q[$];
  int         done_q[$], lf_done_q[$];   // expected sampling edge of done, -1 = untimed
  int         rdy_mode = 0, hold_cnt = 0;
  bit         hold_armed = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0d, expected none (t=%0t)", name, act, $time);
  endtask

  // Reference frame: decimal text of the snapshot, centiseconds clamped to 99.
  task automatic push_frame(input int h, input int m, input int s, input int c, input bit lf_only);
    string str;
    str = $sformatf("%02d:%02d:%02d.%02d", h, m, s, (c > 99) ? 99 : c);
    for (int i = 0; i < str.len(); i++) begin
      if (lf_only) lf_exp_q.push_back(str[i]);
      else         exp_q.push_back(str[i]);
    end
    if (lf_only) lf_exp_q.push_back(8'h0A);
    else begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  // tx_ready pattern generator; the hold freezes the sink for 5 cycles on byte 3.
  always @(posedge clk) begin
    #1;
    if (hold_armed && tx_valid && byte_in_frame == 3) begin
      hold_cnt   = 5;
      hold_armed = 1'b0;
    end
    if (hold_cnt > 0) begin
      tx_ready = 1'b0;
      hold_cnt--;
    end else if (rdy_mode == 1) tx_ready = ~tx_ready;
    else if (rdy_mode == 2)     tx_ready = ($urandom_range(0, 3) != 0);
    else                        tx_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs", 32'({tx_valid, busy, done}), 0);
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(tx_valid), 1);
        check("stall_data_held", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        check("busy_in_frame", 32'(busy), 1);
        if (exp_q.size() == 0) flag("unexpected_byte", int'(tx_data));
        else check("frame_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        byte_in_frame++;
      end
      if (done) begin
        n_done++;
        check("done_after_full_frame", byte_in_frame, 13);
        check("valid_low_at_done", 32'(tx_valid), 0);
        byte_in_frame = 0;
        if (done_q.size() == 0) flag("unexpected_done", cyc + 1);
        else begin
          int d;
          d = done_q.pop_front();
          if (d >= 0) check("done_edge", cyc + 1, d);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (lf_tx_valid) begin
        check("lf_busy_in_frame", 32'(lf_busy), 1);
        if (lf_exp_q.size() == 0) flag("lf_unexpected_byte", int'(lf_tx_data));
        else check("lf_frame_byte", 32'(lf_tx_data), 32'(lf_exp_q.pop_front()));
        lf_byte_in_frame++;
      end
      if (lf_done) begin
        lf_n_done++;
        check("lf_done_after_full_frame", lf_byte_in_frame, 12);
        lf_byte_in_frame = 0;
        if (lf_done_q.size() == 0) flag("lf_unexpected_done", cyc + 1);
        else check("lf_done_edge", cyc + 1, lf_done_q.pop_front());
      end
    end
  end

  task automatic wait_done(input int target);
    int i = 0;
    while (n_done < target && i < 500) begin
      @(posedge clk);
      i++;
    end
    if (n_done < target) flag("done_timeout", n_done);
  endtask

  task automatic wait_bytes(input int n);
    int i = 0;
    while (byte_in_frame < n && i < 300) begin
      @(posedge clk);
      i++;
    end
    if (byte_in_frame < n) flag("byte_timeout", byte_in_frame);
  endtask

  // req is sampled at edge N = cyc+1; done is expected to be sampled at N+15.
  task automatic issue(input int h, input int m, input int s, input int c, input bit timed);
    @(posedge clk);
    #1;
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
    req  = 1'b1;
    push_frame(h, m, s, c, 1'b0);
    done_q.push_back(timed ? cyc + 1 + 13 + 2 : -1);
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int target, h, m, s, c, saved;
    target = 0;
    rst = 1'b0; req = 1'b0; tx_ready = 1'b1;
    msec = '0; sec = '0; min = '0; hour = '0;
    lf_req = 1'b0; lf_msec = '0; lf_sec = '0; lf_min = '0; lf_hour = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_valid", 32'(tx_valid), 0);
    check("reset_tx_data", 32'(tx_data), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame, tx_ready held high
    issue(12, 34, 56, 7, 1'b1);
    target++;
    wait_done(target);
    #1 check("busy_low_after_basic", 32'(busy), 0);

    // LF-only instance with centisecond saturation
    @(posedge clk);
    #1;
    lf_hour = 5'd23; lf_min = 6'd59; lf_sec = 6'd59; lf_msec = 7'd120; lf_req = 1'b1;
    push_frame(23, 59, 59, 120, 1'b1);
    lf_done_q.push_back(cyc + 1 + 12 + 2);
    @(posedge clk);
    #1 lf_req = 1'b0;
    for (int i = 0; i < 100 && lf_n_done < 1; i++) @(posedge clk);
    check("lf_frame_count", lf_n_done, 1);

    // Backpressure: toggling ready plus a 5-cycle hold on byte 3
    rdy_mode   = 1;
    hold_armed = 1'b1;
    issue(12, 34, 56, 7, 1'b0);
    target++;
    wait_done(target);
    rdy_mode = 0;
    #1 check("busy_low_after_backpressure", 32'(busy), 0);
    check("hold_applied", 32'(hold_armed), 0);

    // Snapshot isolation and ignored mid-frame request
    issue(0, 0, 59, 99, 1'b1);
    target++;
    hour = 5'd1; min = 6'd2; sec = 6'd3; msec = 7'd4;
    wait_bytes(4);
    #1 req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    wait_done(target);
    repeat (30) @(posedge clk);
    check("single_done_snapshot", n_done, target);

    // req held high: back-to-back frames, restart right after DONE
    @(posedge clk);
    #1;
    h = int'($urandom_range(0, 31)); m = int'($urandom_range(0, 63));
    s = int'($urandom_range(0, 63)); c = int'($urandom_range(0, 127));
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
    req = 1'b1;
    push_frame(h, m, s, c, 1'b0);
    push_frame(h, m, s, c, 1'b0);
    done_q.push_back(cyc + 16);
    done_q.push_back(cyc + 32);
    target++;
    wait_done(target);
    wait_bytes(2);
    #1 req = 1'b0;
    target++;
    wait_done(target);
    #1 check("busy_low_after_held_req", 32'(busy), 0);

    // Randomised frames under random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)), int'($urandom_range(0, 127)), 1'b0);
      target++;
      wait_done(target);
    end
    rdy_mode = 0;

`ifdef WTCH_AUTO_REPORT_EN
    h = int'($urandom_range(0, 23)); m = int'($urandom_range(0, 59)); c = int'($urandom_range(0, 99));
    issue(h, m, 4, c, 1'b1);
    target++;
    wait_done(target);
    @(posedge clk);
    #1 sec = 6'd5;
    push_frame(h, m, 5, c, 1'b0);
    done_q.push_back(cyc + 16);
    target++;
    wait_bytes(3);
    #1 sec = 6'd6;
    wait_done(target);
    repeat (30) @(posedge clk);
    check("auto_report_count", n_done, target);
`else
    @(posedge clk);
    #1 sec = (sec == 6'd63) ? 6'd0 : sec + 6'd1;
    repeat (30) @(posedge clk);
    check("no_report_on_sec_change", n_done, target);
    check("idle_after_sec_change", 32'(busy), 0);
`endif

    // Reset mid-frame after byte 5 is accepted
    saved = n_done;
    issue(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
          int'($urandom_range(1, 59)), int'($urandom_range(0, 99)), 1'b0);
    wait_bytes(6);
    #3 rst = 1'b0;
    #1;
    check("async_reset_valid", 32'(tx_valid), 0);
    check("async_reset_busy", 32'(busy), 0);
    exp_q.delete();
    done_q.delete();
    byte_in_frame = 0;
    sec = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    check("no_done_on_abort", n_done, saved);
    issue(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
          int'($urandom_range(0, 63)), int'($urandom_range(0, 127)), 1'b1);
    wait_done(saved + 1);

    repeat (20) @(posedge clk);
    check("exp_queue_drained", exp_q.size(), 0);
    check("lf_exp_queue_drained", lf_exp_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
